iter_shifter: RTL and testbench



---
 rtl/iter_shifter_pkg.sv | 17 +
 rtl/iter_shifter.sv | 89 ++++++++
 tb/tb_iter_shifter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM state values.
package iter_shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_SRL  = 2'b01,
      SHIFT_SRA  = 2'b10,
      SHIFT_PASS = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA one bit per clock under a start/done handshake,
// so the multi-cycle controller can hold EXE until done pulses.
module iter_shifter
   import iter_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [1:0]       shift_op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] shamt_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           state_reg, state_next;
   shift_op_t        op_reg, op_next;
   logic [SHW-1:0]   count_reg, count_next;
   logic [WIDTH-1:0] work_reg, work_next;

   // Only the low SHW bits of the extended shift amount are meaningful.
   logic unused_shamt_hi;
   assign unused_shamt_hi = ^shamt_in[WIDTH-1:SHW];

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                   input shift_op_t       op);
      case (op)
         SHIFT_SLL: shift_step = {v[WIDTH-2:0], 1'b0};
         SHIFT_SRL: shift_step = {1'b0, v[WIDTH-1:1]};
         SHIFT_SRA: shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
         default:   shift_step = v;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ST_IDLE;
         op_reg    <= SHIFT_SLL;
         count_reg <= '0;
         work_reg  <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         count_reg <= count_next;
         work_reg  <= work_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      count_next = count_reg;
      work_next  = work_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            done = (state_reg == ST_DONE);
            if (start) begin
               work_next  = data_in;
               op_next    = shift_op_t'(shift_op);
               count_next = shamt_in[SHW-1:0];
               if (shamt_in[SHW-1:0] == '0 || shift_op == SHIFT_PASS)
                  state_next = ST_DONE;
               else
                  state_next = ST_SHIFT;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy       = 1'b1;
            work_next  = shift_step(work_reg, op_reg);
            count_next = count_reg - 1'b1;
            if (count_reg == SHW'(1))
               state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The working register is the result; it only changes on accept or while shifting.
   assign result = work_reg;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and random checks of iter_shifter: results, done latency, busy length,
// ignored starts, back-to-back starts and asynchronous reset mid-shift.
module tb_iter_shifter;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [1:0]  shift_op;
   logic [31:0] data_in;
   logic [31:0] shamt_in;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests_run    = 0;
   int tests_failed = 0;

   iter_shifter #(.WIDTH(32), .SHW(5)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .shift_op (shift_op),
      .data_in  (data_in),
      .shamt_in (shamt_in),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Issues one start, optionally pokes a stray start at cycle poke_at, and
   // returns latency (edges from acceptance to done, inclusive) and busy count.
   task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s,
                         input int poke_at, output int lat, output int busy_cnt,
                         output logic [31:0] res);
      @(negedge clk);
      start    = 1'b1;
      shift_op = op;
      data_in  = d;
      shamt_in = s;
      @(posedge clk);
      #1;
      start    = 1'b0;
      data_in  = $urandom;
      shamt_in = $urandom;
      shift_op = 2'($urandom_range(0, 3));
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (lat == poke_at) begin
            start    = 1'b1;
            shift_op = 2'b00;
            data_in  = 32'h0000_00FF;
            shamt_in = 32'd1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
      if (!done) check("done_timeout", {31'd0, done}, 32'd1);
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      res = result;
   endtask

   int          lat, bcnt;
   logic [31:0] res, exp_res;
   logic [1:0]  r_op;
   logic [31:0] r_d, r_s;
   int          n;

   initial begin
      rstn     = 1'b0;
      start    = 1'b0;
      shift_op = 2'b00;
      data_in  = '0;
      shamt_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy",   {31'd0, busy}, 32'd0);
      check("reset_done",   {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      run_op(2'b00, 32'h0000_0001, 32'd4, -1, lat, bcnt, res);
      check("sll4_result", res, 32'h0000_0010);
      check("sll4_latency", 32'(lat), 32'd5);
      check("sll4_busy_cycles", 32'(bcnt), 32'd4);
      repeat (3) @(posedge clk);
      #1;
      check("sll4_result_held", result, 32'h0000_0010);
      check("idle_done_low", {31'd0, done}, 32'd0);

      run_op(2'b10, 32'h8000_0000, 32'd31, -1, lat, bcnt, res);
      check("sra31_result", res, 32'hFFFF_FFFF);
      check("sra31_latency", 32'(lat), 32'd32);
      run_op(2'b01, 32'h8000_0000, 32'd31, -1, lat, bcnt, res);
      check("srl31_result", res, 32'h0000_0001);
      check("srl31_latency", 32'(lat), 32'd32);

      run_op(2'b01, 32'hDEAD_BEEF, 32'hFFFF_FFE0, -1, lat, bcnt, res);
      check("zero_shamt_result", res, 32'hDEAD_BEEF);
      check("zero_shamt_latency", 32'(lat), 32'd1);
      check("zero_shamt_busy", 32'(bcnt), 32'd0);

      run_op(2'b11, 32'h1234_5678, 32'd7, -1, lat, bcnt, res);
      check("pass_result", res, 32'h1234_5678);
      check("pass_latency", 32'(lat), 32'd1);

      // Stray start mid-shift is ignored; a start in the DONE cycle is accepted.
      run_op(2'b00, 32'h0000_0001, 32'd8, 3, lat, bcnt, res);
      check("ignore_start_result", res, 32'h0000_0100);
      check("ignore_start_latency", 32'(lat), 32'd9);
      run_op(2'b01, 32'h0000_0100, 32'd8, -1, lat, bcnt, res);
      check("b2b_result", res, 32'h0000_0001);
      check("b2b_latency", 32'(lat), 32'd9);

      // Asynchronous reset in the middle of a 20-bit shift.
      @(negedge clk);
      start    = 1'b1;
      shift_op = 2'b00;
      data_in  = 32'h0000_0003;
      shamt_in = 32'd20;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("midreset_busy_before", {31'd0, busy}, 32'd1);
      rstn = 1'b0;
      #1;
      check("midreset_busy",   {31'd0, busy}, 32'd0);
      check("midreset_done",   {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("midreset_no_done", {31'd0, done | busy}, 32'd0);
      run_op(2'b10, 32'hF000_0000, 32'd4, -1, lat, bcnt, res);
      check("after_reset_result", res, 32'hFF00_0000);
      check("after_reset_latency", 32'(lat), 32'd5);

      for (int i = 0; i < 500; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_d  = $urandom;
         r_s  = $urandom;
         n    = int'(r_s[4:0]);
         case (r_op)
            2'b00:   exp_res = r_d << n;
            2'b01:   exp_res = r_d >> n;
            2'b10:   exp_res = $unsigned($signed(r_d) >>> n);
            default: exp_res = r_d;
         endcase
         run_op(r_op, r_d, r_s, -1, lat, bcnt, res);
         check($sformatf("rand%0d_result", i), res, exp_res);
         check($sformatf("rand%0d_latency", i), 32'(lat),
               (r_op == 2'b11) ? 32'd1 : 32'(n + 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
